// File: rtl/cond_eval_unit.sv
// ---------------------------------------------------------------------------
// cond_eval_unit
//   EX-stage condition unit. Holds the NZCV status register, merges masked
//   flag writes from the ALU, and evaluates NUM_CH ARM-style condition fields
//   per cycle to gate writeback/memory enables. Condition-failed instructions
//   are counted in a saturating squash counter.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   stall        freezes status register, result stage and squash counter
//   flush        clears result valids (status register unaffected)
//   flag_we      status write enable
//   flag_in      new flags {N,Z,C,V}
//   flag_mask    per-flag write mask, same bit order as flag_in
//   ch_valid     per-channel instruction valid
//   ch_cond      per-channel condition, channel i at [4i+3:4i]
//   exec         per-channel condition passed (qualified by valid)
//   exec_valid   per-channel result valid
//   cond_illegal per-channel 4'b1111 encoding seen
//   status       stored NZCV
//   squash_cnt   saturating count of valid channels whose condition failed
// ---------------------------------------------------------------------------

// Per-channel condition decode against the shared effective flags.
module cond_eval_lane #(
    parameter int COND_LEN = 4
) (
    input  logic                valid,
    input  logic [COND_LEN-1:0] cond,
    input  logic [3:0]          flags,
    output logic                pass,
    output logic                illegal,
    output logic                fail
);
    logic n, z, c, v;
    logic truth;

    assign {n, z, c, v} = flags;

    always_comb begin
        truth = 1'b0;
        case (cond)
            4'b0000: truth = z;                  // EQ
            4'b0001: truth = ~z;                 // NE
            4'b0010: truth = c;                  // CS
            4'b0011: truth = ~c;                 // CC
            4'b0100: truth = n;                  // MI
            4'b0101: truth = ~n;                 // PL
            4'b0110: truth = v;                  // VS
            4'b0111: truth = ~v;                 // VC
            4'b1000: truth = c & ~z;             // HI
            4'b1001: truth = ~c | z;             // LS
            4'b1010: truth = ~(n ^ v);           // GE
            4'b1011: truth = n ^ v;              // LT
            4'b1100: truth = ~z & ~(n ^ v);      // GT
            4'b1101: truth = z | (n ^ v);        // LE
            4'b1110: truth = 1'b1;               // AL
            default: truth = 1'b0;               // 1111: never executes
        endcase
    end

    assign pass    = valid & truth;
    assign illegal = valid & (cond == 4'b1111);
    // Illegal encodings evaluate false, so they count as squashed too.
    assign fail    = valid & ~truth;
endmodule

module cond_eval_unit #(
    parameter int NUM_CH   = 1,
    parameter int COND_LEN = 4,
    parameter int REG_OUT  = 1,
    parameter int FWD_EN   = 1,
    parameter int CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         flush,
    input  logic                         flag_we,
    input  logic [3:0]                   flag_in,
    input  logic [3:0]                   flag_mask,
    input  logic [NUM_CH-1:0]            ch_valid,
    input  logic [NUM_CH*COND_LEN-1:0]   ch_cond,
    output logic [NUM_CH-1:0]            exec,
    output logic [NUM_CH-1:0]            exec_valid,
    output logic [NUM_CH-1:0]            cond_illegal,
    output logic [3:0]                   status,
    output logic [CNT_W-1:0]             squash_cnt
);
    typedef struct packed {
        logic [NUM_CH-1:0] valid;
        logic [NUM_CH-1:0] exec;
        logic [NUM_CH-1:0] illegal;
    } res_t;

    logic [3:0]        flags_nxt;
    logic [3:0]        flags_eff;
    logic [NUM_CH-1:0] pass;
    logic [NUM_CH-1:0] illegal;
    logic [NUM_CH-1:0] fail;
    logic [CNT_W:0]    cnt_sum;
    res_t              res_nxt;
    res_t              res;

    // Masked merge of the ALU flag write into the stored value.
    assign flags_nxt = (status & ~flag_mask) | (flag_in & flag_mask);

    // Forwarding ignores stall: evaluation still sees the in-flight write
    // even though the register itself will not take it this cycle.
    assign flags_eff = (FWD_EN != 0 && flag_we) ? flags_nxt : status;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            status <= 4'b0000;
        else if (flag_we && !stall)
            status <= flags_nxt;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        cond_eval_lane #(.COND_LEN(COND_LEN)) u_lane (
            .valid   (ch_valid[i]),
            .cond    (ch_cond[i*COND_LEN +: COND_LEN]),
            .flags   (flags_eff),
            .pass    (pass[i]),
            .illegal (illegal[i]),
            .fail    (fail[i])
        );
    end

    always_comb begin
        res_nxt         = '0;
        res_nxt.valid   = ch_valid;
        res_nxt.exec    = pass;
        res_nxt.illegal = illegal;
    end

    if (REG_OUT != 0) begin : g_reg
        // flush beats stall beats load.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                res <= '0;
            else if (flush)
                res <= '0;
            else if (!stall)
                res <= res_nxt;
        end
    end else begin : g_comb
        always_comb begin
            res       = res_nxt;
            res.valid = ch_valid & ~{NUM_CH{flush}};
        end
    end

    assign exec         = res.exec;
    assign exec_valid   = res.valid;
    assign cond_illegal = res.illegal;

    // One extra bit of headroom: a full counter plus at most NUM_CH fails
    // cannot overflow it, so the top bit flags saturation.
    always_comb begin
        cnt_sum = {1'b0, squash_cnt};
        for (int i = 0; i < NUM_CH; i++)
            cnt_sum = cnt_sum + {{CNT_W{1'b0}}, fail[i]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            squash_cnt <= '0;
        else if (!stall && !flush)
            squash_cnt <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
endmodule

// File: tb/tb_cond_eval_unit.sv
// ---------------------------------------------------------------------------
// tb_cond_eval_unit
//   Two instances share stimulus: dut0 (4 channels, registered, forwarding,
//   16-bit counter) and dut1 (2 channels, combinational, no forwarding,
//   4-bit counter). A behavioural model tracks both; a negedge process
//   compares every cycle, and directed steps pin literal values.
// ---------------------------------------------------------------------------
module tb_cond_eval_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, flag_we = 1'b0;
    logic [3:0]  flag_in = '0, flag_mask = '0;
    logic [3:0]  ch_valid = '0;
    logic [15:0] ch_cond = '0;

    logic [3:0]  exec0, ev0, il0, st0;
    logic [15:0] cnt0;
    logic [1:0]  exec1, ev1, il1;
    logic [3:0]  st1;
    logic [3:0]  cnt1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    cond_eval_unit #(.NUM_CH(4), .REG_OUT(1), .FWD_EN(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flag_we(flag_we),
        .flag_in(flag_in), .flag_mask(flag_mask), .ch_valid(ch_valid),
        .ch_cond(ch_cond), .exec(exec0), .exec_valid(ev0), .cond_illegal(il0),
        .status(st0), .squash_cnt(cnt0));

    cond_eval_unit #(.NUM_CH(2), .REG_OUT(0), .FWD_EN(0), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flag_we(flag_we),
        .flag_in(flag_in), .flag_mask(flag_mask), .ch_valid(ch_valid[1:0]),
        .ch_cond(ch_cond[7:0]), .exec(exec1), .exec_valid(ev1), .cond_illegal(il1),
        .status(st1), .squash_cnt(cnt1));

    // ---------------- behavioural model ----------------
    // Condition codes come in complementary pairs: odd code = inverse of
    // the even one, except AL / 1111.
    function automatic bit truth(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        if (c == 4'hF) return 1'b0;
        if (c == 4'hE) return 1'b1;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            default: base = !z && (n == v);
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic void model_eval(input int nch, input logic [3:0] f,
                                       output logic [3:0] p, output logic [3:0] il,
                                       output int fails);
        logic [3:0] c;
        p = '0; il = '0; fails = 0;
        for (int i = 0; i < nch; i++) begin
            c = ch_cond[i*4 +: 4];
            if (ch_valid[i]) begin
                p[i]  = truth(c, f);
                il[i] = (c == 4'hF);
                if (!p[i]) fails++;
            end
        end
    endfunction

    logic [3:0] m_status = '0, m_ex0 = '0, m_ev0 = '0, m_il0 = '0;
    int         m_cnt0 = 0, m_cnt1 = 0;

    always @(posedge clk or negedge rst) begin
        logic [3:0] merged, p0, i0, p1, i1;
        int f0, f1;
        if (!rst) begin
            m_status = '0; m_ex0 = '0; m_ev0 = '0; m_il0 = '0;
            m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            merged = (m_status & ~flag_mask) | (flag_in & flag_mask);
            model_eval(4, flag_we ? merged : m_status, p0, i0, f0);
            model_eval(2, m_status, p1, i1, f1);
            if (!stall && !flush) begin
                m_cnt0 = (m_cnt0 + f0 > 65535) ? 65535 : m_cnt0 + f0;
                m_cnt1 = (m_cnt1 + f1 > 15) ? 15 : m_cnt1 + f1;
            end
            if (flush) begin
                m_ex0 = '0; m_ev0 = '0; m_il0 = '0;
            end else if (!stall) begin
                m_ex0 = p0; m_ev0 = ch_valid; m_il0 = i0;
            end
            if (flag_we && !stall) m_status = merged;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic [3:0] p1, i1;
        int f1;
        if (chk_en) begin
            chk("exec0", exec0, m_ex0);
            chk("exec_valid0", ev0, m_ev0);
            chk("illegal0", il0, m_il0);
            chk("status0", st0, m_status);
            chk("cnt0", cnt0, m_cnt0);
            model_eval(2, m_status, p1, i1, f1);
            chk("exec1", exec1, p1[1:0]);
            chk("exec_valid1", ev1, ch_valid[1:0] & ~{2{flush}});
            chk("illegal1", il1, i1[1:0]);
            chk("status1", st1, m_status);
            chk("cnt1", cnt1, m_cnt1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input bit st, input bit fl, input bit we, input logic [3:0] fi,
                          input logic [3:0] fm, input logic [3:0] v, input logic [15:0] c);
        stall = st; flush = fl; flag_we = we; flag_in = fi; flag_mask = fm;
        ch_valid = v; ch_cond = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_exec", exec0, 0);
        chk("rst_ev", ev0, 0);
        chk("rst_il", il0, 0);
        chk("rst_status", st0, 0);
        chk("rst_cnt", cnt0, 0);
        rst = 1'b1;
        chk_en = 1'b1;

        // EQ with Z=0 fails
        set_in(0, 0, 0, 4'h0, 4'h0, 4'b0001, 16'h0000);
        tick();
        chk("A_exec", exec0, 4'b0000);
        chk("A_ev", ev0, 4'b0001);
        chk("A_cnt", cnt0, 1);
        chk("A_status", st0, 4'b0000);

        // same-cycle flag write Z=1 with EQ: forwarded vs not
        set_in(0, 0, 1, 4'b0100, 4'hF, 4'b0001, 16'h0000);
        @(negedge clk);
        chk("B_exec_nofwd", exec1[0], 1'b0);
        tick();
        chk("B_exec_fwd", exec0[0], 1'b1);
        chk("B_status", st0, 4'b0100);

        set_in(0, 0, 1, 4'b1001, 4'hF, 4'b0000, 16'h0000);
        tick();
        chk("C_status", st0, 4'b1001);

        // mask only Z with flag_in=0: status keeps 1001; GE,LT,GT,LE
        set_in(0, 0, 1, 4'b0000, 4'b0100, 4'hF, 16'hDCBA);
        tick();
        chk("D_exec", exec0, 4'b0101);
        chk("D_status", st0, 4'b1001);
        chk("D_cnt", cnt0, 3);

        // ch0 AL, ch1 1111, ch2 HI (C=0), ch3 idle
        set_in(0, 0, 0, 4'h0, 4'h0, 4'b0111, 16'h08FE);
        @(negedge clk);
        chk("E_exec1", exec1, 2'b01);
        chk("E_il1", il1, 2'b10);
        tick();
        chk("E_exec0", exec0, 4'b0001);
        chk("E_il0", il0, 4'b0010);
        chk("E_cnt0", cnt0, 5);
        chk("E_cnt1", cnt1, 4);

        // stall with a pending flag write
        set_in(1, 0, 1, 4'b0110, 4'hF, 4'b0001, 16'h0000);
        repeat (3) begin
            tick();
            chk("F_status", st0, 4'b1001);
            chk("F_exec", exec0, 4'b0001);
            chk("F_cnt", cnt0, 5);
        end

        // flush still writes status
        set_in(0, 1, 1, 4'b0000, 4'b0001, 4'b0001, 16'h000E);
        tick();
        chk("G_ev", ev0, 4'b0000);
        chk("G_cnt", cnt0, 5);
        chk("G_status", st0, 4'b1000);

        // random phase
        for (int k = 0; k < 400; k++) begin
            set_in($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 1) == 1, 4'($urandom), 4'($urandom),
                   4'($urandom), 16'($urandom));
            tick();
        end

        // asynchronous reset mid-cycle
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("R_exec", exec0, 0);
        chk("R_ev", ev0, 0);
        chk("R_il", il0, 0);
        chk("R_status", st0, 0);
        chk("R_cnt0", cnt0, 0);
        chk("R_cnt1", cnt1, 0);
        set_in(0, 0, 0, 4'h0, 4'h0, 4'b0001, 16'h000F);
        #1;
        rst = 1'b1;

        // saturation of the 4-bit counter
        repeat (20) tick();
        chk("S_cnt1", cnt1, 15);
        chk("S_cnt0", cnt0, 20);
        chk("S_il0", il0, 4'b0001);

        set_in(0, 0, 0, 4'h0, 4'h0, 4'h0, 16'h0);
        tick();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
